// File: rtl/emif_master_z.sv
// +--------------------------------------------------------------------------+
// | Module   : emif_master_z                                                 |
// | Function : single-word EMIF initiator with programmable setup, strobe,   |
// |            hold and turnaround timing.                                   |
// | Option   : `define EMIF_MASTER_ARDY_EN adds async ready + timeout.       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

module emif_master_z #(
  parameter int unsigned SETUP_CYC  = 2,
  parameter int unsigned STROBE_CYC = 4,
  parameter int unsigned HOLD_CYC   = 2,
  parameter int unsigned TA_CYC     = 1
`ifdef EMIF_MASTER_ARDY_EN
  ,
  parameter int unsigned ARDY_TMO   = 64
`endif
) (
  input  logic        clk_100m,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_wr,
  input  logic [23:0] cmd_addr,
  input  logic [15:0] cmd_wdata,
  input  logic [1:0]  cmd_byten,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        busy,
`ifdef EMIF_MASTER_ARDY_EN
  input  logic        emif_ardy_i,
  output logic        rsp_err,
`endif
  output logic [23:0] emif_addr_o,
  output logic [1:0]  emif_byten_o,
  output logic        emif_cen_o,
  output logic        emif_wen_o,
  output logic        emif_oen_o,
  output logic [15:0] emif_data_o,
  output logic        emif_data_oe,
  input  logic [15:0] emif_data_i
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_STROBE = 3'd2,
    S_HOLD   = 3'd3,
    S_TA     = 3'd4
  } state_t;

  localparam logic [7:0] c_setup_ld  = 8'(SETUP_CYC - 1);
  localparam logic [7:0] c_strobe_ld = 8'(STROBE_CYC - 1);
  localparam logic [7:0] c_hold_ld   = 8'(HOLD_CYC - 1);
  localparam logic [7:0] c_ta_ld     = (TA_CYC == 0) ? 8'd0 : 8'(TA_CYC - 1);

  state_t     r_state;
  logic [7:0] r_cnt;
  logic       r_wr;
  logic       w_cnt_zero;
  logic       w_strobe_done;

  assign w_cnt_zero = (r_cnt == 8'd0);
  assign busy       = ~cmd_ready;

`ifdef EMIF_MASTER_ARDY_EN
  logic        r_ardy_meta;
  logic        r_ardy_sync;
  logic [15:0] r_ext;
  logic        w_tmo;

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      r_ardy_meta <= 1'b0;
      r_ardy_sync <= 1'b0;
    end else begin
      r_ardy_meta <= emif_ardy_i;
      r_ardy_sync <= r_ardy_meta;
    end
  end

  // Minimum strobe first, then wait for ready or give up after ARDY_TMO extra cycles
  assign w_tmo         = (r_ext == 16'(ARDY_TMO));
  assign w_strobe_done = w_cnt_zero && (r_ardy_sync || w_tmo);
`else
  assign w_strobe_done = w_cnt_zero;
`endif

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= 8'd0;
      r_wr         <= 1'b0;
      cmd_ready    <= 1'b1;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= 16'd0;
      emif_addr_o  <= 24'd0;
      emif_byten_o <= 2'b11;
      emif_cen_o   <= 1'b1;
      emif_wen_o   <= 1'b1;
      emif_oen_o   <= 1'b1;
      emif_data_o  <= 16'd0;
      emif_data_oe <= 1'b0;
`ifdef EMIF_MASTER_ARDY_EN
      r_ext        <= 16'd0;
      rsp_err      <= 1'b0;
`endif
    end else begin
      rsp_valid <= 1'b0;
`ifdef EMIF_MASTER_ARDY_EN
      rsp_err   <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_state      <= S_SETUP;
            r_cnt        <= c_setup_ld;
            r_wr         <= cmd_wr;
            cmd_ready    <= 1'b0;
            emif_addr_o  <= {cmd_addr[0], cmd_addr[23:1]};
            emif_byten_o <= cmd_byten;
            emif_cen_o   <= 1'b0;
            if (cmd_wr) begin
              emif_data_o  <= cmd_wdata;
              emif_data_oe <= 1'b1;
            end
          end
        end
        S_SETUP: begin
          if (w_cnt_zero) begin
            r_state    <= S_STROBE;
            r_cnt      <= c_strobe_ld;
            emif_wen_o <= ~r_wr;
            emif_oen_o <= r_wr;
`ifdef EMIF_MASTER_ARDY_EN
            r_ext      <= 16'd0;
`endif
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        S_STROBE: begin
          if (w_strobe_done) begin
            r_state    <= S_HOLD;
            r_cnt      <= c_hold_ld;
            emif_wen_o <= 1'b1;
            emif_oen_o <= 1'b1;
            if (!r_wr) begin
              rsp_rdata <= emif_data_i;
              rsp_valid <= 1'b1;
            end
`ifdef EMIF_MASTER_ARDY_EN
            rsp_err <= ~r_ardy_sync;
`endif
          end else if (!w_cnt_zero) begin
            r_cnt <= r_cnt - 8'd1;
          end
`ifdef EMIF_MASTER_ARDY_EN
          else begin
            r_ext <= r_ext + 16'd1;
          end
`endif
        end
        S_HOLD: begin
          if (w_cnt_zero) begin
            emif_cen_o   <= 1'b1;
            emif_byten_o <= 2'b11;
            emif_data_oe <= 1'b0;
            if (TA_CYC == 0) begin
              r_state   <= S_IDLE;
              cmd_ready <= 1'b1;
            end else begin
              r_state <= S_TA;
              r_cnt   <= c_ta_ld;
            end
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        S_TA: begin
          if (w_cnt_zero) begin
            r_state   <= S_IDLE;
            cmd_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_emif_master_z.sv
// +--------------------------------------------------------------------------+
// | Module   : tb_emif_master_z                                              |
// | Function : directed self-checking bench for emif_master_z (defaults).    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_emif_master_z;

  logic        clk_100m = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_wr;
  logic [23:0] cmd_addr;
  logic [15:0] cmd_wdata;
  logic [1:0]  cmd_byten;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        busy;
  logic [23:0] emif_addr_o;
  logic [1:0]  emif_byten_o;
  logic        emif_cen_o;
  logic        emif_wen_o;
  logic        emif_oen_o;
  logic [15:0] emif_data_o;
  logic        emif_data_oe;
  logic [15:0] emif_data_i;
`ifdef EMIF_MASTER_ARDY_EN
  logic        emif_ardy_i = 1'b1;
  logic        rsp_err;
`endif

  int checks = 0;
  int errors = 0;

  emif_master_z dut (
    .clk_100m     (clk_100m),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_wr       (cmd_wr),
    .cmd_addr     (cmd_addr),
    .cmd_wdata    (cmd_wdata),
    .cmd_byten    (cmd_byten),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .busy         (busy),
`ifdef EMIF_MASTER_ARDY_EN
    .emif_ardy_i  (emif_ardy_i),
    .rsp_err      (rsp_err),
`endif
    .emif_addr_o  (emif_addr_o),
    .emif_byten_o (emif_byten_o),
    .emif_cen_o   (emif_cen_o),
    .emif_wen_o   (emif_wen_o),
    .emif_oen_o   (emif_oen_o),
    .emif_data_o  (emif_data_o),
    .emif_data_oe (emif_data_oe),
    .emif_data_i  (emif_data_i)
  );

  always #5 clk_100m = ~clk_100m;

  task automatic tick();
    @(posedge clk_100m);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // {cen, wen, oen, data_oe, cmd_ready, rsp_valid}
  function automatic logic [5:0] bus_vec();
    return {emif_cen_o, emif_wen_o, emif_oen_o, emif_data_oe, cmd_ready, rsp_valid};
  endfunction

  // Expected bus state in cycle i (1 = first cycle after the accept edge), default timing
  function automatic logic [5:0] exp_vec(input int i, input logic wr);
    logic strobe, active;
    active = (i >= 1 && i <= 8);
    strobe = (i >= 3 && i <= 6);
    return {~active, ~(wr & strobe), ~(~wr & strobe), wr & active, (i >= 10), (~wr & (i == 7))};
  endfunction

  task automatic run_txn(input string name, input logic wr, input logic [23:0] addr,
                         input logic [15:0] wdata, input logic [1:0] byten,
                         input logic [23:0] exp_addr);
    cmd_valid = 1'b1;
    cmd_wr    = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_byten = byten;
    tick();
    cmd_valid = 1'b0;
    cmd_wr    = ~wr;
    cmd_addr  = 24'(~addr);
    cmd_wdata = 16'(~wdata);
    for (int i = 1; i <= 10; i++) begin
      check($sformatf("%s_bus_c%0d", name, i), 32'(bus_vec()), 32'(exp_vec(i, wr)));
      if (i == 1) begin
        check({name, "_addr"}, 32'(emif_addr_o), 32'(exp_addr));
        check({name, "_byten"}, 32'(emif_byten_o), 32'(byten));
        if (wr) check({name, "_wdata"}, 32'(emif_data_o), 32'(wdata));
      end
      if (i == 9) begin
        check({name, "_ta_byten"}, 32'(emif_byten_o), 32'h3);
        check({name, "_ta_addr"}, 32'(emif_addr_o), 32'(exp_addr));
      end
      if (i < 10) tick();
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    cmd_valid   = 1'b0;
    cmd_wr      = 1'b0;
    cmd_addr    = 24'd0;
    cmd_wdata   = 16'd0;
    cmd_byten   = 2'b00;
    emif_data_i = 16'd0;

    // Reset with random command activity
    for (int i = 0; i < 5; i++) begin
      tick();
      cmd_valid = 1'($urandom);
      cmd_wr    = 1'($urandom);
      cmd_addr  = 24'($urandom);
      cmd_wdata = 16'($urandom);
      cmd_byten = 2'($urandom);
    end
    check("rst_bus", 32'(bus_vec()), 32'b111010);
    check("rst_byten", 32'(emif_byten_o), 32'h3);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_addr_data", {8'(emif_addr_o), 8'(emif_data_o), 16'(rsp_rdata)}, 32'h0);
    cmd_valid = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("idle_bus", 32'(bus_vec()), 32'b111010);

    emif_data_i = 16'h1234;
    run_txn("wr1", 1'b1, 24'h000001, 16'hA5A5, 2'b00, 24'h800000);
    run_txn("rd1", 1'b0, 24'h000002, 16'h0000, 2'b00, 24'h000001);
    check("rd1_rdata", 32'(rsp_rdata), 32'h1234);
    run_txn("wr_b11", 1'b1, 24'h000003, 16'h0F0F, 2'b11, 24'h800001);
    check("rd1_rdata_held", 32'(rsp_rdata), 32'h1234);

    // Back-to-back: write then read with cmd_valid held high
    emif_data_i = 16'h5A5A;
    cmd_valid = 1'b1;
    cmd_wr    = 1'b1;
    cmd_addr  = 24'h000010;
    cmd_wdata = 16'hBEEF;
    cmd_byten = 2'b00;
    tick();
    cmd_wr   = 1'b0;
    cmd_addr = 24'h000011;
    for (int i = 1; i <= 19; i++) begin
      check($sformatf("b2b_cen_c%0d", i), 32'(emif_cen_o),
            32'(!((i >= 1 && i <= 8) || (i >= 11 && i <= 18))));
      check($sformatf("b2b_oe_c%0d", i), 32'(emif_data_oe), 32'(i >= 1 && i <= 8));
      check($sformatf("b2b_wenoen_c%0d", i), 32'({emif_wen_o, emif_oen_o}),
            32'({!(i >= 3 && i <= 6), !(i >= 13 && i <= 16)}));
      if (i == 1) check("b2b_wr_addr", 32'(emif_addr_o), 32'h000008);
      if (i == 11) begin
        check("b2b_rd_addr", 32'(emif_addr_o), 32'h800008);
        cmd_valid = 1'b0;
      end
      if (i == 17) check("b2b_rsp", {15'd0, rsp_valid, rsp_rdata}, {15'd0, 1'b1, 16'h5A5A});
      if (i < 19) tick();
    end

    // Reset during the second strobe cycle of a write
    tick();
    cmd_valid = 1'b1;
    cmd_wr    = 1'b1;
    cmd_addr  = 24'h000020;
    cmd_wdata = 16'h7777;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("mid_strobe_bus", 32'(bus_vec()), 32'b001100);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_bus", 32'(bus_vec()), 32'b111010);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("in_rst_rsp_%0d", i), 32'(rsp_valid), 32'h0);
    end
    rst_n = 1'b1;
    tick();
    check("post_rst_ready", 32'(cmd_ready), 32'h1);
    emif_data_i = 16'hC0DE;
    run_txn("rd2", 1'b0, 24'h000031, 16'h0000, 2'b01, 24'h800018);
    check("rd2_rdata", 32'(rsp_rdata), 32'hC0DE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
